// File: rtl/icache_sa_if.sv
// icache_sa_if: fetch-side and refill-side signals of the set-associative I-cache.
// master = IF/MemCtrl side, slave = cache side.
interface icache_sa_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] pc_if_in;
    logic                  rdy_if_in;
    logic [INST_WIDTH-1:0] inst_if_out;
    logic                  rdy_if_out;
    logic [INST_WIDTH-1:0] inst_mc_in;
    logic                  rdy_inst_mc_in;
    logic [ADDR_WIDTH-1:0] inst_addr_mc_out;
    logic                  rdy_inst_mc_out;

    modport slave (
        input  pc_if_in, rdy_if_in, inst_mc_in, rdy_inst_mc_in,
        output inst_if_out, rdy_if_out, inst_addr_mc_out, rdy_inst_mc_out
    );

    modport master (
        output pc_if_in, rdy_if_in, inst_mc_in, rdy_inst_mc_in,
        input  inst_if_out, rdy_if_out, inst_addr_mc_out, rdy_inst_mc_out
    );
endinterface

// File: rtl/icache_sa.sv
// icache_sa: set-associative I-cache, same-cycle hits, line refill, round-robin victims.
// Optional flush port enabled by defining ICACHE_FLUSH_EN.
module icache_sa #(
    parameter int ADDR_WIDTH     = 32,
    parameter int INST_WIDTH     = 32,
    parameter int WAYS           = 2,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    icache_sa_if.slave bus
`ifdef ICACHE_FLUSH_EN
    ,
    input  logic       flush_in
`endif
);
    localparam int LOG_WPL = $clog2(WORDS_PER_LINE);
    localparam int OFF_W   = (WORDS_PER_LINE > 1) ? LOG_WPL : 1;
    localparam int IDX_W   = $clog2(SETS);
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W   = ADDR_WIDTH - 2 - LOG_WPL - IDX_W;

    typedef logic [OFF_W-1:0] off_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [WAY_W-1:0] way_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef enum logic {IDLE, FILL} state_t;

    localparam off_t LAST_BEAT = off_t'(WORDS_PER_LINE - 1);
    localparam way_t LAST_WAY  = way_t'(WAYS - 1);

    logic [INST_WIDTH-1:0] data_q [WAYS][SETS][WORDS_PER_LINE];
    tag_t                  tag_q  [WAYS][SETS];
    logic [WAYS-1:0]       valid_q [SETS];
    way_t                  rr_q    [SETS];

    state_t                state_q, state_d;
    off_t                  beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  req_q, req_d;
    way_t                  vic_q, vic_d;
    tag_t                  ftag_q, ftag_d;
    idx_t                  fidx_q, fidx_d;

    logic start, beat_we, last;
    logic flush;
    logic hit_any, inv_found;
    way_t hit_way, inv_way;

    off_t off;
    idx_t idx;
    tag_t tag;

`ifdef ICACHE_FLUSH_EN
    assign flush = flush_in;
`else
    assign flush = 1'b0;
`endif

    assign off = off_t'((bus.pc_if_in >> 2) & ADDR_WIDTH'(WORDS_PER_LINE - 1));
    assign idx = idx_t'(bus.pc_if_in >> (2 + LOG_WPL));
    assign tag = tag_t'(bus.pc_if_in >> (2 + LOG_WPL + IDX_W));

    // Tag lookup in the addressed set and lowest-index invalid way
    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][way_t'(w)] && tag_q[w][idx] == tag) begin
                hit_any = 1'b1;
                hit_way = way_t'(w);
            end
            if (!valid_q[idx][way_t'(w)]) begin
                inv_found = 1'b1;
                inv_way   = way_t'(w);
            end
        end
    end

    assign bus.rdy_if_out = !rst_in && rdy_in && !flush
                          && bus.rdy_if_in && hit_any;
    assign bus.inst_if_out      = data_q[hit_way][idx][off];
    assign bus.rdy_inst_mc_out  = req_q;
    assign bus.inst_addr_mc_out = addr_q;

    // Miss detection, victim choice and refill beat sequencing
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        req_d   = req_q;
        vic_d   = vic_q;
        ftag_d  = ftag_q;
        fidx_d  = fidx_q;
        start   = 1'b0;
        beat_we = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.rdy_if_in && !hit_any) begin
                    start   = 1'b1;
                    state_d = FILL;
                    vic_d   = inv_found ? inv_way : rr_q[idx];
                    ftag_d  = tag;
                    fidx_d  = idx;
                    addr_d  = bus.pc_if_in & ~ADDR_WIDTH'(WORDS_PER_LINE * 4 - 1);
                    req_d   = 1'b1;
                    beat_d  = '0;
                end
            end
            FILL: begin
                if (bus.rdy_inst_mc_in) begin
                    beat_we = 1'b1;
                    beat_d  = beat_q + off_t'(1);
                    addr_d  = addr_q + ADDR_WIDTH'(4);
                    if (beat_q == LAST_BEAT) begin
                        last    = 1'b1;
                        beat_d  = '0;
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, valid bits and replacement pointers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (rdy_in) begin
            if (flush) begin
                state_q <= IDLE;
                beat_q  <= '0;
                req_q   <= 1'b0;
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    rr_q[s]    <= '0;
                end
            end else begin
                state_q <= state_d;
                beat_q  <= beat_d;
                addr_q  <= addr_d;
                req_q   <= req_d;
                vic_q   <= vic_d;
                ftag_q  <= ftag_d;
                fidx_q  <= fidx_d;
                if (start) begin
                    valid_q[idx][vic_d] <= 1'b0;
                    if (!inv_found)
                        rr_q[idx] <= (rr_q[idx] == LAST_WAY) ? '0 : rr_q[idx] + way_t'(1);
                end
                if (last)
                    valid_q[fidx_q][vic_q] <= 1'b1;
            end
        end
    end

    // Line storage: refill words and tags, never reset
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush && beat_we) begin
            data_q[vic_q][fidx_q][beat_q] <= bus.inst_mc_in;
            if (last)
                tag_q[vic_q][fidx_q] <= ftag_q;
        end
    end
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed plan plus random traffic against a line-level cache model.
// Memory content is a fixed hash of the address, so any hit must return mem(pc).
module tb_icache_sa;
    localparam int W = 2;
    localparam int S = 64;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    icache_sa_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

    icache_sa #(
        .ADDR_WIDTH(32), .INST_WIDTH(32), .WAYS(W), .SETS(S), .WORDS_PER_LINE(L)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
`ifdef ICACHE_FLUSH_EN
        ,
        .flush_in (flush)
`endif
    );

    int errs = 0;
    int checks = 0;

    bit          mv  [S][W];
    int unsigned mt  [S][W];
    int          mrr [S];
    bit          mfill;
    bit          mreq;
    int          mbeat;
    int          mvic;
    int          mset;
    int unsigned mtag;
    logic [31:0] maddr;

    function automatic logic [31:0] mem(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    task automatic chk(string tg, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tg, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < S; s++) begin
            mrr[s] = 0;
            for (int w = 0; w < W; w++) mv[s][w] = 1'b0;
        end
        mfill = 1'b0;
        mreq  = 1'b0;
        mbeat = 0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model
    task automatic step(bit r, bit rd, bit fl, bit rif, logic [31:0] pc, bit mcr);
        bit h;
        bit exp_hit;
        int st;
        int v;
        int unsigned tg;
`ifndef ICACHE_FLUSH_EN
        fl = 1'b0;
`endif
        @(negedge clk);
        rst = r;
        rdy = rd;
        flush = fl;
        bus.rdy_if_in = rif;
        bus.pc_if_in = pc;
        bus.rdy_inst_mc_in = mcr;
        bus.inst_mc_in = mem(maddr);
        #1;
        st = int'((pc >> 4) & 32'h3F);
        tg = pc >> 10;
        h = 1'b0;
        for (int w = 0; w < W; w++)
            if (mv[st][w] && mt[st][w] == tg) h = 1'b1;
        exp_hit = !r && rd && !fl && rif && h;
        chk("hit", {31'b0, bus.rdy_if_out}, {31'b0, exp_hit});
        if (exp_hit) chk("inst", bus.inst_if_out, mem(pc));
        chk("req", {31'b0, bus.rdy_inst_mc_out}, {31'b0, mreq});
        chk("addr", bus.inst_addr_mc_out, maddr);
        if (r) begin
            model_clear();
            maddr = '0;
        end else if (rd) begin
            if (fl) begin
                model_clear();
            end else if (!mfill) begin
                if (rif && !h) begin
                    v = -1;
                    for (int w = W - 1; w >= 0; w--)
                        if (!mv[st][w]) v = w;
                    if (v < 0) begin
                        v = mrr[st];
                        mrr[st] = (mrr[st] + 1) % W;
                    end
                    mv[st][v] = 1'b0;
                    mfill = 1'b1;
                    mreq = 1'b1;
                    maddr = pc & ~32'hF;
                    mbeat = 0;
                    mset = st;
                    mtag = tg;
                    mvic = v;
                end
            end else if (mcr) begin
                maddr = maddr + 32'd4;
                mbeat++;
                if (mbeat == L) begin
                    mv[mset][mvic] = 1'b1;
                    mt[mset][mvic] = mtag;
                    mfill = 1'b0;
                    mreq = 1'b0;
                    mbeat = 0;
                end
            end
        end
    endtask

    task automatic fill(logic [31:0] pc);
        step(0, 1, 0, 1, pc, 0);
        repeat (L) step(0, 1, 0, 0, 32'h0, 1);
    endtask

    initial begin
        logic [31:0] pc;
        bus.rdy_if_in = 1'b0;
        bus.pc_if_in = '0;
        bus.rdy_inst_mc_in = 1'b0;
        bus.inst_mc_in = '0;
        model_clear();
        maddr = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);

        step(1, 1, 0, 1, 32'h100, 1);
        step(0, 1, 0, 1, 32'h100, 0);
        step(0, 1, 0, 1, 32'h100, 0);
        repeat (L) step(0, 1, 0, 1, 32'h100, 1);
        step(0, 1, 0, 1, 32'h100, 0);
        step(0, 1, 0, 1, 32'h10C, 1);

        fill(32'h500);
        step(0, 1, 0, 1, 32'h900, 0);
        step(0, 1, 0, 1, 32'h504, 1);
        step(0, 1, 0, 1, 32'h904, 0);
        repeat (3) step(0, 0, 0, 1, 32'h504, 1);
        step(0, 1, 0, 1, 32'h904, 1);
        step(0, 1, 0, 0, 32'h0, 1);
        step(0, 1, 0, 1, 32'h504, 1);
        step(0, 1, 0, 1, 32'h900, 0);
        step(0, 1, 0, 1, 32'h500, 0);
        step(0, 1, 0, 1, 32'h100, 0);
        step(0, 1, 0, 0, 32'h0, 1);
        step(1, 1, 0, 0, 32'h0, 1);
        step(0, 1, 0, 1, 32'h500, 0);
        step(0, 1, 0, 0, 32'h500, 1);

`ifdef ICACHE_FLUSH_EN
        repeat (L) step(0, 1, 0, 0, 32'h0, 1);
        step(0, 1, 0, 1, 32'h100, 0);
        step(0, 1, 0, 0, 32'h0, 1);
        step(0, 1, 1, 1, 32'h500, 1);
        step(0, 1, 0, 1, 32'h500, 0);
        repeat (L) step(0, 1, 0, 0, 32'h0, 1);
        fill(32'h900);
        fill(32'hD00);
        step(0, 1, 0, 1, 32'h100, 0);
`endif

        for (int i = 0; i < 4000; i++) begin
            pc = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4)
               | ($urandom_range(0, 3) << 2);
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 70),
                 pc,
                 ($urandom_range(0, 99) < 60));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised set-associative instruction cache; successor to the direct-mapped single-word cache.
- Sits between IF and MemCtrl; serves hits combinationally in the same cycle.
- On a miss, refills a whole multi-word line from MemCtrl, one word per beat.
- Adds configurable ways, sets and line length, per-set round-robin replacement, and hit-under-miss.

Parameters:
- ADDR_WIDTH, 32, address width.
- INST_WIDTH, 32, instruction/word width.
- WAYS, 2, associativity; power of two, 1..8.
- SETS, 64, sets per way; power of two, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, 1..16.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global ready; low = freeze all state.
- pc_if_in  in  ADDR_WIDTH  fetch address, word aligned.
- rdy_if_in  in  1  fetch request valid.
- inst_if_out  out  INST_WIDTH  instruction of hit word.
- rdy_if_out  out  1  hit, same cycle (combinational).
- inst_mc_in  in  INST_WIDTH  refill word from MemCtrl.
- rdy_inst_mc_in  in  1  refill word valid for the current inst_addr_mc_out.
- inst_addr_mc_out  out  ADDR_WIDTH  refill word address.
- rdy_inst_mc_out  out  1  refill request, level.
- flush_in  in  1  invalidate all lines; port exists only with ICACHE_FLUSH_EN.

Behaviour:
- Address split:
  - offset = pc[log2(WORDS_PER_LINE)+1 : 2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- Per way/set storage: valid bit, tag, WORDS_PER_LINE words. Per set: round-robin pointer of log2(WAYS) bits.
- Hit condition: rdy_if_out = !rst_in && rdy_in && rdy_if_in && any way in index set is valid with matching tag.
  - inst_if_out = word[offset] of the hitting way; it is a don't-care when there is no hit.
  - At most one way matches; this is guaranteed by the fill logic.
- FSM states IDLE and FILL.
- IDLE:
  - Enter FILL on rdy_if_in && !hit.
  - Latch fill_tag, fill_index and victim way.
  - Victim selection: lowest-index invalid way; if none is invalid, way rr[index], and rr[index] then increments, wrapping.
  - Clear the victim's valid bit at this edge.
  - Set inst_addr_mc_out = line base (offset bits zero) and rdy_inst_mc_out = 1; both are registered and visible the next cycle.
- FILL, on each cycle with rdy_inst_mc_in = 1:
  - Write inst_mc_in to victim word[beat] and increment beat.
  - Advance inst_addr_mc_out by 4.
  - On the last beat (beat == WORDS_PER_LINE-1), at the same edge: write the tag, set valid, drop rdy_inst_mc_out to 0, return to IDLE.
  - A miss can start again from the next cycle.
- Hit-under-miss: during FILL, hits to any other valid line are served normally.
  - The line being filled never hits until valid is set, so no partial-line hits.
- A miss during FILL, including to the line in flight, starts no new request; IF keeps waiting.
- rdy_inst_mc_in is ignored in IDLE.
- rdy_in = 0:
  - No state changes; registered outputs hold.
  - rdy_if_out = 0.
  - rdy_inst_mc_in pulses are ignored (MemCtrl is stalled likewise).
- Reset, including mid-FILL:
  - All valid bits = 0, rr pointers = 0, state = IDLE, beat = 0.
  - rdy_inst_mc_out = 0, inst_addr_mc_out = 0.
  - The in-flight refill is abandoned.
- Storage arrays are not reset.

Optional Feature:
- Macro ICACHE_FLUSH_EN.
- When defined, flush_in port exists. flush_in = 1 with rdy_in = 1:
  - Clears all valid bits and rr pointers at the edge.
  - Aborts any FILL: rdy_inst_mc_out = 0 next cycle, state IDLE.
  - Forces rdy_if_out = 0 that cycle.
  - Flush has priority over both miss start and refill beat.
- When undefined: no port, no flush logic. Only reset invalidates.

Test Plan (WAYS=2, SETS=64, WORDS_PER_LINE=4; index = pc[9:4], tag = pc[31:10]):
- Cold miss:
  - Stimulus: reset, then pc 0x100 with rdy_if_in = 1.
  - Response: rdy_if_out = 0; next cycle rdy_inst_mc_out = 1 with address 0x100.
  - MemCtrl returns 0xA0,0xA1,0xA2,0xA3 on consecutive cycles → addresses 0x100, 0x104, 0x108, 0x10C are presented in turn.
  - rdy_inst_mc_out falls after the 4th beat; the following cycle rdy_if_out = 1 with inst 0xA0.
- Line hit: after the cold-miss fill, pc 0x10C → rdy_if_out = 1 same cycle, inst 0xA3, rdy_inst_mc_out stays 0.
- Replacement:
  - Fill 0x100, then 0x500 (both set 0x10).
  - Then 0x900 evicts way 0 (rr = 0) → 0x500 hits, 0x100 misses.
- Hit-under-miss: during the 0x900 fill, pc 0x504 → rdy_if_out = 1 immediately.
  - pc 0x904 mid-fill → rdy_if_out = 0 and no second request.
- Stall and reset:
  - rdy_in = 0 for 3 cycles after beat 1 with rdy_inst_mc_in pulsing → beat count unchanged, rdy_if_out = 0.
  - rst_in mid-fill → rdy_inst_mc_out = 0 next cycle, and previously filled 0x500 now misses.
- Flush (ICACHE_FLUSH_EN): flush_in during the 0x100 fill → request drops, 0x500 misses afterwards, rr restarts at way 0.
